hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and redirect controller for the 5-stage MIPS core. It is the single source of the freeze, stall, bubble and flush controls for the PC, the IF/ID register and the ID/EX register. It detects load-use hazards, freezes the pipe while the data memory is busy, and sequences taken-branch/jump redirects, including redirects that arrive during a freeze. It also keeps two saturating performance counters.

## Interface
Parameters:
- `REG_W`, default 5: register-specifier width.
- `CNT_W`, default 16: performance-counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `idex_memread`  in  1  instruction in EX is a load.
- `idex_rt`  in  REG_W  load destination register in EX.
- `ifid_rs`  in  REG_W  rs of the instruction in ID.
- `ifid_rt`  in  REG_W  rt of the instruction in ID.
- `ifid_uses_rt`  in  1  ID instruction reads rt as a source.
- `branch_taken`  in  1  ID resolved a taken branch or jump this cycle.
- `branch_target`  in  32  redirect target, valid with `branch_taken`.
- `dmem_busy`  in  1  data memory not ready; whole pipe must hold.
- `pc_we`  out  1  PC register write enable.
- `pc_redirect`  out  1  PC mux selects `pc_target`.
- `pc_target`  out  32  redirect address.
- `ifid_stall`  out  1  IF/ID hold, active-high.
- `ifid_flush`  out  1  IF/ID clear, **active-low**.
- `idex_bubble`  out  1  zero ID/EX control fields on this edge.
- `pipe_freeze`  out  1  hold ID/EX, EX/MEM and MEM/WB.
- `stall_cycles`  out  CNT_W  count of cycles with `pc_we`=0, outside reset.
- `redirect_count`  out  CNT_W  count of issued redirects.

## Operation
State machine states:
- `RUN`
- `FREEZE`: busy, no redirect pending.
- `FREEZE_PEND`: busy, redirect captured.
- `REDIRECT`: issue a captured redirect.

Load-use hazard (`lu`):
- `lu` = `idex_memread` & `idex_rt`≠0 & (`idex_rt`==`ifid_rs` | (`ifid_uses_rt` & `idex_rt`==`ifid_rt`)).

Outputs are combinational from state and inputs, evaluated in priority order (first match wins):
1. **`rst`=1**
   - Outputs: `pc_we`=0, `ifid_flush`=0, `idex_bubble`=1; all other outputs 0.
   - Next state `RUN`; counters and `pc_target` cleared to 0.
2. **`dmem_busy`=1** (any state)
   - Outputs: `pc_we`=0, `ifid_stall`=1, `pipe_freeze`=1, `ifid_flush`=1, `idex_bubble`=0, `pc_redirect`=0.
   - If `branch_taken` is high in `RUN`, or in `FREEZE` (the ID instruction holds, so it may re-assert):
     - capture `branch_target` into the `pc_target` register;
     - go to `FREEZE_PEND`.
   - Otherwise remain in `FREEZE`, or stay in `FREEZE_PEND` if already there.
3. **`REDIRECT`, or `FREEZE_PEND` with `dmem_busy`=0**
   - Outputs: `pc_we`=1, `pc_redirect`=1 with the captured `pc_target`, `ifid_flush`=0, `idex_bubble`=1.
   - Increment `redirect_count`; next state `RUN`.
4. **`RUN`/`FREEZE` with `lu`=1**
   - Outputs: `pc_we`=0, `ifid_stall`=1, `idex_bubble`=1, `ifid_flush`=1.
   - `branch_taken` is ignored this cycle; ID re-resolves next cycle with forwarded data. Next state `RUN`.
5. **`branch_taken`=1**
   - Outputs: `pc_we`=1, `pc_redirect`=1, `ifid_flush`=0.
   - `pc_target` passes combinationally from `branch_target`, and the register also loads it.
   - Increment `redirect_count`; next state `RUN`.
6. **Otherwise**
   - Outputs: `pc_we`=1, `ifid_flush`=1, all others 0; next state `RUN`.

Exits from freeze:
- `FREEZE` with `dmem_busy`=0 behaves as `RUN` (rules 4–6).
- `REDIRECT` is reached only through the internal path and always lasts one cycle.

Counters:
- Widths are fixed at CNT_W and saturate at all-ones; no wrap.
- `stall_cycles` increments on every non-reset cycle with `pc_we`=0.

## Timing
- Zero-latency control: all outputs respond in the same cycle as their inputs. The affected registers act on the next rising edge.
- A load-use stall costs exactly one cycle. On the following cycle the load is in MEM, `lu` is false, and the pipe proceeds.
- A taken branch in `RUN` costs one flushed slot: the wrong-path fetch is cleared at the same edge the PC loads the target.
- Branch during a freeze: the redirect issues on the first cycle with `dmem_busy`=0. That costs one extra slot relative to no freeze.
- Back-to-back `branch_taken` on consecutive `RUN` cycles: each is honoured; the second overrides the PC.
- `rst` asserted mid-freeze or with a redirect pending discards the pending redirect. Output is the reset values on the next evaluated cycle.
- `ifid_flush` and `ifid_stall` are never both asserted (`ifid_flush`=0 together with `ifid_stall`=1 never occurs).

## Test plan
- **Reset:** hold `rst` for 3 cycles with random inputs → `pc_we`=0, `ifid_flush`=0, `idex_bubble`=1, both counters 0. First cycle after reset with quiet inputs → `pc_we`=1, `ifid_flush`=1.
- **Load-use:** `idex_memread`=1, `idex_rt`=8, `ifid_rs`=8 for one cycle → `pc_we`=0, `ifid_stall`=1, `idex_bubble`=1 for exactly 1 cycle, `stall_cycles`=1.
  - Repeat with `idex_rt`=0 → no stall.
  - Repeat with `ifid_rt`=8, `ifid_uses_rt`=0 → no stall.
- **Taken branch:** `branch_taken`=1, `branch_target`=0x0040_0100 → same cycle `pc_redirect`=1, `pc_target`=0x0040_0100, `ifid_flush`=0; `redirect_count`=1.
- **Branch during freeze:**
  - Stimulus: `dmem_busy`=1 for 4 cycles, `branch_taken` pulsed with 0x0000_2000 in cycle 2.
  - During freeze: `pc_we`=0, `pipe_freeze`=1 throughout, no redirect.
  - On the cycle `dmem_busy` falls: `pc_redirect`=1, `pc_target`=0x0000_2000, `ifid_flush`=0.
  - Counters: `stall_cycles`=4, `redirect_count`=1.
- **Priority:** `lu`=1 and `branch_taken`=1 in the same cycle → stall only, `pc_redirect`=0. Add `dmem_busy`=1 → freeze, redirect captured.
- **Reset mid-pend and saturation:**
  - `rst` asserted while in `FREEZE_PEND` → no redirect ever issues.
  - With CNT_W=4, run 20 stall cycles → `stall_cycles` holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard/redirect controller.
// The master drives the hazard inputs; the slave (hazard_ctrl) drives the pipe controls.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             ifid_uses_rt;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             dmem_busy;

    logic             pc_we;
    logic             pc_redirect;
    logic [31:0]      pc_target;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] redirect_count;

    modport master (
        output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
               branch_taken, branch_target, dmem_busy,
        input  pc_we, pc_redirect, pc_target, ifid_stall, ifid_flush,
               idex_bubble, pipe_freeze, stall_cycles, redirect_count
    );

    modport slave (
        input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
               branch_taken, branch_target, dmem_busy,
        output pc_we, pc_redirect, pc_target, ifid_stall, ifid_flush,
               idex_bubble, pipe_freeze, stall_cycles, redirect_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and redirect controller for the 5-stage MIPS pipe: load-use stalls,
// data-memory freezes, taken-branch redirects (including ones caught mid-freeze).
module hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);
    localparam logic [1:0] S_RUN         = 2'd0;
    localparam logic [1:0] S_FREEZE      = 2'd1;
    localparam logic [1:0] S_FREEZE_PEND = 2'd2;
    localparam logic [1:0] S_REDIRECT    = 2'd3;

    logic [1:0]       r_state;
    logic [31:0]      r_pc_target;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_redirect_count;

    logic [1:0]  w_next;
    logic        w_lu;
    logic        w_capture;
    logic        w_redir_inc;
    logic        w_pc_we;
    logic        w_pc_redirect;
    logic [31:0] w_pc_target;
    logic        w_ifid_stall;
    logic        w_ifid_flush;
    logic        w_idex_bubble;
    logic        w_pipe_freeze;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_lu = bus.idex_memread && (bus.idex_rt != '0) &&
                  ((bus.idex_rt == bus.ifid_rs) ||
                   (bus.ifid_uses_rt && (bus.idex_rt == bus.ifid_rt)));

    // Priority chain: reset, memory freeze, pending redirect, load-use, branch, run.
    always_comb begin
        w_next        = S_RUN;
        w_capture     = 1'b0;
        w_redir_inc   = 1'b0;
        w_pc_we       = 1'b0;
        w_pc_redirect = 1'b0;
        w_pc_target   = 32'h0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b0;
        w_pipe_freeze = 1'b0;
        if (rst) begin
            w_ifid_flush  = 1'b0;
            w_idex_bubble = 1'b1;
        end else if (bus.dmem_busy) begin
            w_ifid_stall  = 1'b1;
            w_pipe_freeze = 1'b1;
            // ID holds during a freeze, so a branch may resolve in FREEZE too.
            if (bus.branch_taken && (r_state == S_RUN || r_state == S_FREEZE)) begin
                w_capture = 1'b1;
                w_next    = S_FREEZE_PEND;
            end else if (r_state == S_FREEZE_PEND) begin
                w_next = S_FREEZE_PEND;
            end else begin
                w_next = S_FREEZE;
            end
        end else if (r_state == S_REDIRECT || r_state == S_FREEZE_PEND) begin
            w_pc_we       = 1'b1;
            w_pc_redirect = 1'b1;
            w_pc_target   = r_pc_target;
            w_ifid_flush  = 1'b0;
            w_idex_bubble = 1'b1;
            w_redir_inc   = 1'b1;
        end else if (w_lu) begin
            w_ifid_stall  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (bus.branch_taken) begin
            w_pc_we       = 1'b1;
            w_pc_redirect = 1'b1;
            w_pc_target   = bus.branch_target;
            w_ifid_flush  = 1'b0;
            w_capture     = 1'b1;
            w_redir_inc   = 1'b1;
        end else begin
            w_pc_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_RUN;
            r_pc_target      <= 32'h0;
            r_stall_cycles   <= '0;
            r_redirect_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture)   r_pc_target      <= bus.branch_target;
            if (!w_pc_we)    r_stall_cycles   <= sat_inc(r_stall_cycles);
            if (w_redir_inc) r_redirect_count <= sat_inc(r_redirect_count);
        end
    end

    assign bus.pc_we          = w_pc_we;
    assign bus.pc_redirect    = w_pc_redirect;
    assign bus.pc_target      = w_pc_target;
    assign bus.ifid_stall     = w_ifid_stall;
    assign bus.ifid_flush     = w_ifid_flush;
    assign bus.idex_bubble    = w_idex_bubble;
    assign bus.pipe_freeze    = w_pipe_freeze;
    assign bus.stall_cycles   = r_stall_cycles;
    assign bus.redirect_count = r_redirect_count;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl plus a counter-saturation sequence on a narrow instance.
module tb_hazard_ctrl;
    logic clk;
    logic rst;
    logic rst2;

    hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) bus();
    hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  bus2();

    hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    hazard_ctrl #(.REG_W(5), .CNT_W(4))  dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control pattern {pc_we, pc_redirect, ifid_stall, ifid_flush, idex_bubble, pipe_freeze}
    localparam logic [5:0] P_RST  = 6'b000010;
    localparam logic [5:0] P_NORM = 6'b100100;
    localparam logic [5:0] P_LU   = 6'b001110;
    localparam logic [5:0] P_BR   = 6'b110000;
    localparam logic [5:0] P_FRZ  = 6'b001101;
    localparam logic [5:0] P_RDR  = 6'b110010;

    typedef struct {
        logic        rst;
        logic        mr;
        logic [4:0]  xrt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urt;
        logic        bt;
        logic [31:0] tgt;
        logic        busy;
        logic [5:0]  pat;
        logic [31:0] etgt;
        logic        ck;
        int          sc;
        int          rc;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic r, input logic mr, input logic [4:0] xrt,
                                input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                                input logic bt, input logic [31:0] tgt, input logic busy,
                                input logic [5:0] pat, input logic [31:0] etgt,
                                input logic ck, input int sc, input int rc);
        vec_t v;
        v.rst = r; v.mr = mr; v.xrt = xrt; v.rs = rs; v.rt = rt; v.urt = urt;
        v.bt = bt; v.tgt = tgt; v.busy = busy; v.pat = pat; v.etgt = etgt;
        v.ck = ck; v.sc = sc; v.rc = rc;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row=%0d got=%0h expected=%0h", nm, row, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        bus.idex_memread = 0; bus.idex_rt = 0; bus.ifid_rs = 0; bus.ifid_rt = 0;
        bus.ifid_uses_rt = 0; bus.branch_taken = 0; bus.branch_target = 0; bus.dmem_busy = 0;
        bus2.idex_memread = 0; bus2.idex_rt = 0; bus2.ifid_rs = 0; bus2.ifid_rt = 0;
        bus2.ifid_uses_rt = 0; bus2.branch_taken = 0; bus2.branch_target = 0; bus2.dmem_busy = 0;

        //          rst mr xrt rs rt urt bt tgt           busy pat     etgt          ck sc rc
        // reset held 3 cycles with busy/branch/load-use noise on the inputs
        vq.push_back(mk(1, 1, 8, 8, 8, 1, 1, 32'h0000_1234, 1, P_RST,  32'h0,         0, 0, 0));
        vq.push_back(mk(1, 1, 3, 3, 7, 0, 1, 32'h0000_5678, 1, P_RST,  32'h0,         1, 0, 0));
        vq.push_back(mk(1, 0, 9, 1, 9, 1, 1, 32'hdead_beef, 0, P_RST,  32'h0,         1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, P_NORM, 32'h0,         1, 0, 0));
        // load-use on rs, then the quiet follow-up cycle
        vq.push_back(mk(0, 1, 8, 8, 0, 0, 0, 32'h0,         0, P_LU,   32'h0,         1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, P_NORM, 32'h0,         1, 1, 0));
        // load to $zero never stalls; rt match without rt use never stalls; with use it does
        vq.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h0,         0, P_NORM, 32'h0,         1, 1, 0));
        vq.push_back(mk(0, 1, 8, 3, 8, 0, 0, 32'h0,         0, P_NORM, 32'h0,         1, 1, 0));
        vq.push_back(mk(0, 1, 8, 3, 8, 1, 0, 32'h0,         0, P_LU,   32'h0,         1, 1, 0));
        // taken branch, then back-to-back taken branch
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0040_0100, 0, P_BR,   32'h0040_0100, 1, 2, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0040_0200, 0, P_BR,   32'h0040_0200, 1, 2, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, P_NORM, 32'h0,         1, 2, 2));
        // 4-cycle freeze with branch pulsed in cycle 2, redirect issues when busy falls
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         1, P_FRZ,  32'h0,         1, 2, 2));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0000_2000, 1, P_FRZ,  32'h0,         1, 3, 2));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         1, P_FRZ,  32'h0,         1, 4, 2));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         1, P_FRZ,  32'h0,         1, 5, 2));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, P_RDR,  32'h0000_2000, 1, 6, 2));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, P_NORM, 32'h0,         1, 6, 3));
        // load-use beats branch; freeze beats both and captures the target
        vq.push_back(mk(0, 1, 8, 8, 0, 0, 1, 32'h0000_3000, 0, P_LU,   32'h0,         1, 6, 3));
        vq.push_back(mk(0, 1, 8, 8, 0, 0, 1, 32'h0000_3000, 1, P_FRZ,  32'h0,         1, 7, 3));
        // reset while a redirect is pending: it must never issue
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,         0, P_RST,  32'h0,         1, 8, 3));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, P_NORM, 32'h0,         1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, P_NORM, 32'h0,         1, 0, 0));
        // plain freeze, then load-use on the exit cycle from FREEZE
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         1, P_FRZ,  32'h0,         1, 0, 0));
        vq.push_back(mk(0, 1, 5, 5, 0, 0, 0, 32'h0,         0, P_LU,   32'h0,         1, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0, P_NORM, 32'h0,         1, 2, 0));

        foreach (vq[i]) begin
            @(negedge clk);
            rst                  = vq[i].rst;
            bus.idex_memread     = vq[i].mr;
            bus.idex_rt          = vq[i].xrt;
            bus.ifid_rs          = vq[i].rs;
            bus.ifid_rt          = vq[i].rt;
            bus.ifid_uses_rt     = vq[i].urt;
            bus.branch_taken     = vq[i].bt;
            bus.branch_target    = vq[i].tgt;
            bus.dmem_busy        = vq[i].busy;
            #1;
            chk("pc_we",       i, {31'b0, bus.pc_we},       {31'b0, vq[i].pat[5]});
            chk("pc_redirect", i, {31'b0, bus.pc_redirect}, {31'b0, vq[i].pat[4]});
            chk("ifid_stall",  i, {31'b0, bus.ifid_stall},  {31'b0, vq[i].pat[3]});
            chk("ifid_flush",  i, {31'b0, bus.ifid_flush},  {31'b0, vq[i].pat[2]});
            chk("idex_bubble", i, {31'b0, bus.idex_bubble}, {31'b0, vq[i].pat[1]});
            chk("pipe_freeze", i, {31'b0, bus.pipe_freeze}, {31'b0, vq[i].pat[0]});
            chk("pc_target",   i, bus.pc_target,            vq[i].etgt);
            chk("flush_vs_stall", i, {31'b0, (!bus.ifid_flush && bus.ifid_stall)}, 32'h0);
            if (vq[i].ck) begin
                chk("stall_cycles",   i, {16'b0, bus.stall_cycles},   vq[i].sc);
                chk("redirect_count", i, {16'b0, bus.redirect_count}, vq[i].rc);
            end
        end

        // 4-bit counter saturation: 20 freeze cycles must hold at 15
        @(negedge clk);
        rst2 = 1'b0;
        bus2.dmem_busy = 1'b1;
        repeat (14) @(negedge clk);
        #1;
        chk("sat_stall_14", 100, {28'b0, bus2.stall_cycles}, 32'd14);
        repeat (6) @(negedge clk);
        #1;
        chk("sat_stall_15", 101, {28'b0, bus2.stall_cycles}, 32'd15);
        chk("sat_redirects", 101, {28'b0, bus2.redirect_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
